// File: rtl/cg_pkg.sv
//------------------------------------------------------------------------------
// cg_pkg : shared state encoding, creg bit map and timing defaults for the
//          coilgun fire sequencer.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package cg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_PULSE = 3'd2,
        ST_DEAD  = 3'd3,
        ST_COOL  = 3'd4,
        ST_FAULT = 3'd5
    } cg_state_e;

    localparam int CREG_ARM  = 0;
    localparam int CREG_FIRE = 1;
    localparam int CREG_CLR  = 2;

    localparam int DEF_DEAD_CYC = 32;
    localparam int DEF_COOL_CYC = 4096;

    function automatic int cg_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cg_fire_seq_if.sv
//------------------------------------------------------------------------------
// cg_fire_seq_if : control/status bundle between creg source and fire sequencer.
//                  Adds I_gate when CG_SENSOR_ADVANCE_EN is defined.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface cg_fire_seq_if #(
    parameter int N_COILS = 4,
    parameter int PW      = 16
);
    logic [7:0]         I_creg;
    logic [PW-1:0]      I_pulse_len;
    logic [N_COILS-1:0] O_coil;
    logic               O_busy;
    logic               O_done;
    logic               O_fault;
    logic [2:0]         O_state;
`ifdef CG_SENSOR_ADVANCE_EN
    logic [N_COILS-1:0] I_gate;

    modport master (
        output I_creg, I_pulse_len, I_gate,
        input  O_coil, O_busy, O_done, O_fault, O_state
    );
    modport slave (
        input  I_creg, I_pulse_len, I_gate,
        output O_coil, O_busy, O_done, O_fault, O_state
    );
`else
    modport master (
        output I_creg, I_pulse_len,
        input  O_coil, O_busy, O_done, O_fault, O_state
    );
    modport slave (
        input  I_creg, I_pulse_len,
        output O_coil, O_busy, O_done, O_fault, O_state
    );
`endif
endinterface

`default_nettype wire

// File: rtl/cg_sync.sv
//------------------------------------------------------------------------------
// cg_sync : WIDTH-bit two-flop synchronizer with optional registered
//           rising-edge output.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cg_sync #(
    parameter int WIDTH   = 1,
    parameter bit EDGE_EN = 1'b0
) (
    input  logic             I_clk,
    input  logic             I_rst_n,
    input  logic [WIDTH-1:0] I_d,
    output logic [WIDTH-1:0] O_sync,
    output logic [WIDTH-1:0] O_rise
);
    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = I_d;
        sync_d = meta_q;
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign O_sync = sync_q;

    generate
        if (EDGE_EN) begin : g_edge
            logic [WIDTH-1:0] prev_q, prev_d;
            logic [WIDTH-1:0] rise_q, rise_d;

            always_comb begin
                prev_d = sync_q;
                rise_d = sync_q & ~prev_q;
            end

            always_ff @(posedge I_clk or negedge I_rst_n) begin
                if (!I_rst_n) begin
                    prev_q <= '0;
                    rise_q <= '0;
                end else begin
                    prev_q <= prev_d;
                    rise_q <= rise_d;
                end
            end

            assign O_rise = rise_q;
        end else begin : g_no_edge
            assign O_rise = '0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/cg_fire_seq.sv
//------------------------------------------------------------------------------
// cg_fire_seq : arm/fire/clear driven one-hot coil-gate sequencer with dead
//               time, cooldown and abort-to-fault.  Optional macro:
//               CG_SENSOR_ADVANCE_EN (optical gate early-advance / stall).
//               Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cg_fire_seq
    import cg_pkg::*;
#(
    parameter int N_COILS  = 4,
    parameter int PW       = 16,
    parameter int DEAD_CYC = DEF_DEAD_CYC,
    parameter int COOL_CYC = DEF_COOL_CYC
) (
    input  logic         I_clk,
    input  logic         I_rst_n,
    cg_fire_seq_if.slave bus
);
    localparam int IW = (N_COILS > 1) ? $clog2(N_COILS) : 1;
    localparam int CW = cg_max(cg_max(PW, $clog2(DEAD_CYC + 1)), $clog2(COOL_CYC + 1));
    localparam logic [IW-1:0] LAST_IDX = IW'(N_COILS - 1);

    logic [7:0] creg_s, creg_rise;
    logic       arm_s, clear_s, fire_edge;
    logic       unused_creg;

    // The edge output is registered, so a fire change settling before edge k
    // is acted on at edge k+3.
    cg_sync #(.WIDTH(8), .EDGE_EN(1'b1)) u_creg_sync (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .I_d     (bus.I_creg),
        .O_sync  (creg_s),
        .O_rise  (creg_rise)
    );

    assign arm_s       = creg_s[CREG_ARM];
    assign clear_s     = creg_s[CREG_CLR];
    assign fire_edge   = creg_rise[CREG_FIRE];
    assign unused_creg = ^{creg_s[7:3], creg_s[CREG_FIRE], creg_rise[7:2], creg_rise[0]};

    cg_state_e          state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      len_q, len_d;
    logic [N_COILS-1:0] coil_q, coil_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;
    logic [PW-1:0]      fire_len;
    logic               pulse_end, pulse_stall;

    assign fire_len = (bus.I_pulse_len == '0) ? PW'(1) : bus.I_pulse_len;

`ifdef CG_SENSOR_ADVANCE_EN
    logic [N_COILS-1:0] gate_s, gate_rise;
    logic               unused_gate;

    cg_sync #(.WIDTH(N_COILS), .EDGE_EN(1'b1)) u_gate_sync (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .I_d     (bus.I_gate),
        .O_sync  (gate_s),
        .O_rise  (gate_rise)
    );

    assign unused_gate = ^gate_s;
    // A gate edge ends the pulse early; running out of len without one is a stall.
    assign pulse_end   = gate_rise[idx_q];
    assign pulse_stall = (cnt_q == CW'(1)) & ~gate_rise[idx_q];
`else
    assign pulse_end   = (cnt_q == CW'(1));
    assign pulse_stall = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arm_s) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!arm_s) begin
                    state_d = ST_IDLE;
                end else if (fire_edge) begin
                    state_d = ST_PULSE;
                    idx_d   = '0;
                    len_d   = fire_len;
                    cnt_d   = CW'(fire_len);
                end
            end
            ST_PULSE: begin
                if (!arm_s) begin
                    state_d = ST_FAULT;
                end else if (pulse_end) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_COOL;
                        cnt_d   = CW'(COOL_CYC);
                    end else begin
                        state_d = ST_DEAD;
                        cnt_d   = CW'(DEAD_CYC);
                    end
                end else if (pulse_stall) begin
                    state_d = ST_FAULT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DEAD: begin
                if (!arm_s) begin
                    state_d = ST_FAULT;
                end else if (cnt_q == CW'(1)) begin
                    state_d = ST_PULSE;
                    idx_d   = idx_q + IW'(1);
                    cnt_d   = CW'(len_q);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_COOL: begin
                // Disarming here does not abort; the cooldown always runs out.
                if (cnt_q == CW'(1)) begin
                    done_d  = 1'b1;
                    state_d = arm_s ? ST_ARMED : ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_FAULT: begin
                if (clear_s && !arm_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        coil_d  = (state_d == ST_PULSE) ? (N_COILS'(1) << idx_d) : '0;
        busy_d  = (state_d == ST_PULSE) || (state_d == ST_DEAD) || (state_d == ST_COOL);
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            coil_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            coil_q  <= coil_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign bus.O_coil  = coil_q;
    assign bus.O_busy  = busy_q;
    assign bus.O_done  = done_q;
    assign bus.O_fault = fault_q;
    assign bus.O_state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_cg_fire_seq.sv
//------------------------------------------------------------------------------
// tb_cg_fire_seq : self-checking bench for cg_fire_seq (default build).
//                  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_cg_fire_seq;

    localparam int N      = 4;
    localparam int PW     = 16;
    localparam int T_DEAD = 32;
    localparam int T_COOL = 4096;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_DEAD  = 3'd3;
    localparam logic [2:0] S_COOL  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    typedef struct {
        int idx;
        int start;
        int len;
    } pulse_t;

    typedef struct {
        int         len;
        int         w;
        bit         drop_arm;
        logic [2:0] end_state;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;

    pulse_t exp_q[$];
    int     done_q[$];

    cg_fire_seq_if #(.N_COILS(N), .PW(PW)) bus ();

    cg_fire_seq #(.N_COILS(N), .PW(PW)) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard: coil pulses and done strobes are matched against queued expectations.
    logic [N-1:0] prev_coil = '0;
    int           st [N];
    always @(negedge clk) begin
        pulse_t p;
        check("onehot", 32'($countones(bus.O_coil) <= 1), 32'd1);
        for (int b = 0; b < N; b++) begin
            if (bus.O_coil[b] && !prev_coil[b]) st[b] = cyc;
            if (!bus.O_coil[b] && prev_coil[b]) begin
                check("pulse_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    p = exp_q.pop_front();
                    check("pulse_idx", b, p.idx);
                    check("pulse_start", st[b], p.start);
                    check("pulse_len", cyc - st[b], p.len);
                end
            end
        end
        prev_coil = bus.O_coil;
        if (bus.O_done === 1'b1) begin
            check("done_pending", 32'(done_q.size() != 0), 32'd1);
            if (done_q.size() != 0) check("done_cyc", cyc, done_q.pop_front());
        end
    end

    task automatic wait_cyc(input int t);
        check("schedule", 32'(cyc <= t), 32'd1);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic ensure_armed();
        if (bus.I_creg[0] !== 1'b1) begin
            @(negedge clk);
            bus.I_creg[0] = 1'b1;
            repeat (4) @(negedge clk);
        end
        check("armed_state", bus.O_state, S_ARMED);
    endtask

    // Fire driven at a negedge settles before edge cyc+1; coil 0 rises at edge cyc+4.
    task automatic do_fire(input int len, input int w, input int n_full, input bit want_done,
                           output int s0);
        @(negedge clk);
        bus.I_pulse_len = PW'(len);
        bus.I_creg[1]   = 1'b1;
        s0 = cyc + 4;
        for (int j = 0; j < n_full; j++) exp_q.push_back('{j, s0 + j * (w + T_DEAD), w});
        if (want_done) done_q.push_back(s0 + (N - 1) * (w + T_DEAD) + w + T_COOL);
        repeat (3) @(negedge clk);
        bus.I_creg[1] = 1'b0;
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_pulse_q"}, exp_q.size(), 0);
        check({tag, "_done_q"}, done_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout cyc=%0d actual=running expected=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[4];
        int   s0, s1, s2, cool0;

        vecs[0] = '{10, 10, 1'b0, S_ARMED};
        vecs[1] = '{0,  1,  1'b0, S_ARMED};
        vecs[2] = '{1,  1,  1'b0, S_ARMED};
        vecs[3] = '{3,  3,  1'b1, S_IDLE};

        bus.I_creg      = 8'h00;
        bus.I_pulse_len = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_coil",  bus.O_coil,  0);
        check("rst_busy",  bus.O_busy,  0);
        check("rst_done",  bus.O_done,  0);
        check("rst_fault", bus.O_fault, 0);
        check("rst_state", bus.O_state, S_IDLE);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Fire with arm low is ignored.
        bus.I_creg = 8'h02;
        repeat (10) @(negedge clk);
        check("noarm_state", bus.O_state, S_IDLE);
        check("noarm_coil",  bus.O_coil,  0);
        bus.I_creg = 8'h00;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            ensure_armed();
            do_fire(vecs[i].len, vecs[i].w, N, 1'b1, s0);
            wait_cyc(s0);
            check("v_pulse_state", bus.O_state, S_PULSE);
            check("v_pulse_busy",  bus.O_busy,  1);
            check("v_coil0",       bus.O_coil,  1);
            wait_cyc(s0 + vecs[i].w);
            check("v_dead_state", bus.O_state, S_DEAD);
            check("v_dead_coil",  bus.O_coil,  0);
            cool0 = s0 + (N - 1) * (vecs[i].w + T_DEAD) + vecs[i].w;
            wait_cyc(cool0 - 1);
            check("v_last_coil", bus.O_coil, 32'(1 << (N - 1)));
            wait_cyc(cool0 + 1);
            check("v_cool_state", bus.O_state, S_COOL);
            check("v_cool_busy",  bus.O_busy,  1);
            if (vecs[i].drop_arm) bus.I_creg[0] = 1'b0;
            wait_cyc(cool0 + T_COOL - 1);
            check("v_predone", bus.O_done, 0);
            wait_cyc(cool0 + T_COOL);
            check("v_done", bus.O_done, 1);
            wait_cyc(cool0 + T_COOL + 1);
            check("v_end_state", bus.O_state, vecs[i].end_state);
            check("v_end_busy",  bus.O_busy,  0);
            check("v_end_done",  bus.O_done,  0);
            check_drained("vec");
        end

        // Re-fire and pulse_len changes during a running sequence have no effect.
        ensure_armed();
        do_fire(10, 10, N, 1'b1, s0);
        cool0 = s0 + (N - 1) * (10 + T_DEAD) + 10;
        wait_cyc(s0 + 5);
        bus.I_pulse_len = PW'(50);
        bus.I_creg[1]   = 1'b1;
        wait_cyc(s0 + 9);
        bus.I_creg[1] = 1'b0;
        wait_cyc(s0 + 15);
        bus.I_creg[1] = 1'b1;
        wait_cyc(s0 + 19);
        bus.I_creg[1] = 1'b0;
        wait_cyc(cool0 + 10);
        bus.I_creg[1] = 1'b1;
        wait_cyc(cool0 + 14);
        bus.I_creg[1] = 1'b0;
        wait_cyc(cool0 + T_COOL + 2);
        check("refire_state", bus.O_state, S_ARMED);
        check_drained("refire");
        bus.I_pulse_len = PW'(10);

        // Disarm during coil 2 pulse aborts into FAULT.
        ensure_armed();
        do_fire(10, 10, 2, 1'b0, s0);
        s2 = s0 + 2 * (10 + T_DEAD);
        exp_q.push_back('{2, s2, 6});
        wait_cyc(s2 + 3);
        check("abort_coil2", bus.O_coil, 4);
        bus.I_creg[0] = 1'b0;
        wait_cyc(s2 + 5);
        check("abort_coil_hold", bus.O_coil, 4);
        wait_cyc(s2 + 6);
        check("abort_coil_off", bus.O_coil,  0);
        check("abort_fault",    bus.O_fault, 1);
        check("abort_state",    bus.O_state, S_FAULT);
        check("abort_busy",     bus.O_busy,  0);
        repeat (40) @(negedge clk);
        bus.I_creg = 8'h05;
        repeat (8) @(negedge clk);
        check("clr_armed_state", bus.O_state, S_FAULT);
        check("clr_armed_fault", bus.O_fault, 1);
        bus.I_creg = 8'h04;
        repeat (5) @(negedge clk);
        check("clr_state", bus.O_state, S_IDLE);
        check("clr_fault", bus.O_fault, 0);
        bus.I_creg = 8'h00;
        repeat (3) @(negedge clk);
        check_drained("abort");

        // Asynchronous reset during coil 1 drops the gate at once.
        ensure_armed();
        do_fire(10, 10, 1, 1'b0, s0);
        s1 = s0 + (10 + T_DEAD);
        exp_q.push_back('{1, s1, 4});
        wait_cyc(s1 + 3);
        check("rst_mid_coil1", bus.O_coil, 2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_coil",  bus.O_coil,  0);
        check("rst_mid_state", bus.O_state, S_IDLE);
        check("rst_mid_busy",  bus.O_busy,  0);
        bus.I_creg = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("post_rst_coil",  bus.O_coil,  0);
        check("post_rst_state", bus.O_state, S_IDLE);
        check("post_rst_fault", bus.O_fault, 0);
        check_drained("reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cg_fire_seq.md
Name: cg_fire_seq

Overview:
- Downstream consumer of the I2C control register byte (creg) in the coilgun top level.
- Turns arm/fire/clear bits into a timed, strictly one-hot coil-gate sequence: coil 0 through N_COILS-1, each on for a programmed pulse length, separated by dead time, then a cooldown.
- Drives the coil gate drivers and status lines; replaces the raw creg[0] indicator path.

Parameters:
- N_COILS, 4, number of coil stages (1..8).
- PW, 16, width of the pulse-length input and the pulse counter.
- DEAD_CYC, 32, all-off cycles between consecutive coils (>=1).
- COOL_CYC, 4096, lockout cycles after the last coil before re-fire (>=1).

Ports:
- I_clk  in  1  system clock.
- I_rst_n  in  1  asynchronous active-low reset.
- I_creg  in  8  control register byte from the I2C slave; asynchronous to I_clk, synchronized internally. Bit 0 = arm, bit 1 = fire (rising edge), bit 2 = fault clear.
- I_pulse_len  in  PW  per-coil on-time in cycles, latched at fire start.
- O_coil  out  N_COILS  coil gate enables, at most one bit high.
- O_busy  out  1  high in PULSE/DEAD/COOL.
- O_done  out  1  1-cycle pulse when the sequence completes normally.
- O_fault  out  1  high in FAULT.
- O_state  out  3  encoded current state (debug).

Behaviour:
- Reset (async, I_rst_n=0): state IDLE; O_coil=0, O_busy=0, O_done=0, O_fault=0, O_state=IDLE. Synchronizer flops and counters are cleared.
- All outputs are registered.
- Sync: each I_creg bit goes through 2 flops. fire_edge = s2 & ~s3 on bit 1.
  - A fire-bit change settling before edge k is first acted on at edge k+3.
- States: IDLE, ARMED, PULSE, DEAD, COOL, FAULT.
- IDLE -> ARMED when arm_s=1. ARMED -> IDLE when arm_s=0.
- ARMED -> PULSE on fire_edge:
  - Latch len = (I_pulse_len==0) ? 1 : I_pulse_len.
  - Set coil index i=0; O_coil[0]=1 from the same edge.
- PULSE:
  - O_coil[i] is high for exactly len cycles, then -> DEAD with O_coil=0.
  - If i==N_COILS-1, go -> COOL instead.
- DEAD: O_coil=0 for exactly DEAD_CYC cycles, then i=i+1 -> PULSE.
- COOL: O_coil=0 for COOL_CYC cycles. Then pulse O_done for 1 cycle and go -> ARMED if arm_s=1, else -> IDLE.
- fire_edge outside ARMED is ignored, never queued. I_pulse_len changes mid-sequence have no effect.
- Abort: arm_s=0 in PULSE or DEAD:
  - O_coil=0 at the next edge, -> FAULT; O_done is not pulsed.
  - arm_s=0 in COOL completes the cooldown normally.
- FAULT: O_fault=1, O_coil=0. Exits to IDLE only when clear_s=1 and arm_s=0. Clear with arm still high is ignored.
- Invariants:
  - popcount(O_coil) <= 1 at all times.
  - No coil is high outside PULSE.
  - Reset mid-pulse drops the coil immediately (async).
- Counters saturate-free: a down-counter is loaded on state entry; the transition fires at count==1.

Optional Feature:
- Macro CG_SENSOR_ADVANCE_EN.
- When defined:
  - Adds input I_gate[N_COILS-1:0], optical projectile gates, synchronized with 2 flops.
  - PULSE for coil i ends early on the rising edge of gate_s[i] if that edge comes before len elapses.
  - If len elapses with no gate edge seen, the sequence goes -> FAULT (projectile stall) instead of DEAD.
- When undefined: no port is added; pulse timing is purely len-based, as above.

Decomposition:
- Package cg_pkg holds:
  - the state enum (3-bit);
  - creg bit index constants CREG_ARM=0, CREG_FIRE=1, CREG_CLR=2;
  - default DEAD/COOL constants shared with the top level.
- One sub-module, cg_sync: a parameterized-width 2-flop synchronizer with optional rising-edge output. It is used for I_creg and, under the macro, I_gate.

Test Plan:
- Nominal fire: N_COILS=4, len=10, DEAD_CYC=32. Set arm, then raise fire.
  - O_coil[0] rises 3 edges later; each coil high 10 cycles, 32 low between.
  - O_done pulses once after COOL_CYC; state returns to ARMED.
- len=0 -> each coil high exactly 1 cycle. Fire toggled during PULSE/DEAD/COOL -> ignored; exactly one sequence runs.
- Drop arm during coil 2 PULSE -> O_coil=0 at the next edge, O_fault=1, no O_done.
  - Clear with arm=1 stays in FAULT; clear with arm=0 goes to IDLE.
- Assert I_rst_n=0 mid-pulse (asynchronous to the clock) -> O_coil=0 immediately, state IDLE, no spurious pulse after release.
- Fire without arm -> stays IDLE, O_coil=0. Change I_pulse_len from 10 to 50 mid-sequence -> remaining coils still run for 10 cycles.
- (CG_SENSOR_ADVANCE_EN) Gate 1 edge at cycle 4 of len=10 -> coil 1 ends after 4 cycles. No gate 2 edge within len -> FAULT.
